// File: rtl/simple_ctrl_error_fifo_param.sv
// Error-feedback FIFO controller for one network stage: counts accepted error samples
// into tap blocks, queues completed blocks and sequences the tap-update pass.
module simple_ctrl_error_fifo_param #(
   parameter int DATA_W     = 32,
   parameter int TAP_W      = 4,
   parameter int FIFO_DEPTH = 2,
   parameter int SUB_WRAP   = 6,
   parameter int NUM_PHASES = 4,
   parameter int WR_DLY     = 4,
   parameter int LATCH_DLY  = 6,
   parameter int STAGE_DLY  = 2
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [TAP_W-1:0]                error_tap_length,
   input  logic                            input_stage,
   input  logic                            state_finish,
   input  logic                            read_finish,
   input  logic                            flush,
   input  logic [DATA_W-1:0]               error_in,
   input  logic                            error_in_vld,
   output logic                            error_in_rdy,
   output logic                            error_valid,
   output logic [DATA_W-1:0]               error_value,
   output logic [TAP_W-1:0]                error_count,
   output logic [$clog2(SUB_WRAP)-1:0]     error_sub_address,
   output logic [$clog2(NUM_PHASES)-1:0]   error_phase,
   output logic [$clog2(NUM_PHASES)-1:0]   error_phase_read,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
   output logic                            error_update_mode,
   output logic                            error_update_latch,
   output logic                            error_update_first,
   output logic                            error_tap_update_out,
   output logic                            error_finish_tap,
   output logic                            stage_error_mode,
   output logic                            stage_error_first
);
   localparam int SA_W = $clog2(SUB_WRAP);
   localparam int PH_W = $clog2(NUM_PHASES);
   localparam int LV_W = $clog2(FIFO_DEPTH+1);

   logic                 acc;
   logic                 finish;
   logic                 consume;
   logic                 wr_vld;
   logic                 update_last;
   logic                 tap_update;
   logic                 first_int;
   logic [WR_DLY-1:0]    wr_vld_sr;
   logic [LATCH_DLY-1:0] latch_sr;
   logic [STAGE_DLY-1:0] smode_sr;
   logic [STAGE_DLY-1:0] sfirst_sr;

   // Input is held off while a full FIFO or the delayed update pass owns the buffer.
   assign error_in_rdy = (fifo_level != LV_W'(FIFO_DEPTH)) & ~wr_vld_sr[WR_DLY-1]
                         & ~latch_sr[LATCH_DLY-1];
   assign acc          = error_in_vld & error_in_rdy;
   assign finish       = acc & (error_count == error_tap_length);
   assign consume      = update_last & tap_update;

   assign error_valid          = acc;
   assign error_value          = error_in;
   assign error_update_mode    = (fifo_level != '0);
   assign error_update_first   = first_int & error_update_latch;
   assign wr_vld               = error_update_latch & ~error_update_first;
   assign error_tap_update_out = tap_update & ~input_stage;
   assign error_finish_tap     = state_finish & error_update_latch & tap_update;
   assign stage_error_mode     = smode_sr[STAGE_DLY-1];
   assign stage_error_first    = sfirst_sr[STAGE_DLY-1];

   always_ff @(posedge clk) begin
      if (reset) begin
         error_count        <= '0;
         error_sub_address  <= '0;
         error_phase        <= '0;
         error_phase_read   <= '0;
         fifo_level         <= '0;
         update_last        <= 1'b0;
         tap_update         <= 1'b0;
         error_update_latch <= 1'b0;
         first_int          <= 1'b0;
         wr_vld_sr          <= '0;
         latch_sr           <= '0;
         smode_sr           <= '0;
         sfirst_sr          <= '0;
      end else begin
         if (acc) begin
            error_count <= finish ? '0 : error_count + 1'b1;
            if (error_sub_address == SA_W'(SUB_WRAP-1)) begin
               error_sub_address <= '0;
               error_phase <= (error_phase == PH_W'(NUM_PHASES-1)) ? '0 : error_phase + 1'b1;
            end else begin
               error_sub_address <= error_sub_address + 1'b1;
            end
         end

         // A block finishing in the same cycle one is consumed leaves the level unchanged.
         if (flush) begin
            fifo_level <= '0;
         end else if (consume && finish) begin
            fifo_level <= fifo_level;
         end else if (finish && fifo_level != LV_W'(FIFO_DEPTH)) begin
            fifo_level <= fifo_level + 1'b1;
         end else if (consume && fifo_level != '0) begin
            fifo_level <= fifo_level - 1'b1;
         end

         update_last <= error_update_mode & state_finish;

         if (input_stage) begin
            tap_update <= 1'b1;
         end else if (update_last) begin
            tap_update <= ~tap_update;
         end

         if (state_finish) begin
            error_update_latch <= error_update_mode;
         end

         first_int <= state_finish ? (error_update_mode & read_finish)
                                   : (error_update_latch & read_finish);

         if (first_int && (!tap_update || input_stage)) begin
            error_phase_read <= (error_phase_read == PH_W'(NUM_PHASES-1)) ? '0
                                : error_phase_read + 1'b1;
         end

         wr_vld_sr <= (wr_vld_sr << 1) | WR_DLY'(wr_vld);
         latch_sr  <= (latch_sr << 1) | LATCH_DLY'(error_update_latch);
         smode_sr  <= (smode_sr << 1) | STAGE_DLY'(error_update_latch);
         sfirst_sr <= (sfirst_sr << 1) | STAGE_DLY'(first_int & error_update_latch);
      end
   end
endmodule

// File: tb/tb_simple_ctrl_error_fifo_param.sv
// Bench for simple_ctrl_error_fifo_param: directed scenarios then random traffic,
// checked per cycle and per accepted sample against a counting reference model.
module tb_simple_ctrl_error_fifo_param;
   localparam int DEPTH = 2;
   localparam int SUBW  = 6;
   localparam int NPH   = 4;
   localparam int WRD   = 4;
   localparam int LATD  = 6;
   localparam int STGD  = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  tap_len = 4'd3;
   logic        input_stage = 1'b0;
   logic        state_finish = 1'b0;
   logic        read_finish = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] error_in = '0;
   logic        error_in_vld = 1'b0;
   logic        error_in_rdy;
   logic        error_valid;
   logic [31:0] error_value;
   logic [3:0]  error_count;
   logic [2:0]  error_sub_address;
   logic [1:0]  error_phase;
   logic [1:0]  error_phase_read;
   logic [1:0]  fifo_level;
   logic        error_update_mode;
   logic        error_update_latch;
   logic        error_update_first;
   logic        error_tap_update_out;
   logic        error_finish_tap;
   logic        stage_error_mode;
   logic        stage_error_first;

   simple_ctrl_error_fifo_param dut (
      .clk(clk), .reset(reset), .error_tap_length(tap_len), .input_stage(input_stage),
      .state_finish(state_finish), .read_finish(read_finish), .flush(flush),
      .error_in(error_in), .error_in_vld(error_in_vld), .error_in_rdy(error_in_rdy),
      .error_valid(error_valid), .error_value(error_value), .error_count(error_count),
      .error_sub_address(error_sub_address), .error_phase(error_phase),
      .error_phase_read(error_phase_read), .fifo_level(fifo_level),
      .error_update_mode(error_update_mode), .error_update_latch(error_update_latch),
      .error_update_first(error_update_first), .error_tap_update_out(error_tap_update_out),
      .error_finish_tap(error_finish_tap), .stage_error_mode(stage_error_mode),
      .stage_error_first(stage_error_first)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       rdy;
      logic [1:0] level;
      logic       mode;
      logic       latch;
      logic       first;
      logic       tapo;
      logic       fintap;
      logic       smode;
      logic       sfirst;
      logic [1:0] rph;
      logic [3:0] cnt;
      logic [2:0] sub;
      logic [1:0] ph;
   } st_t;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  cnt;
      logic [2:0]  sub;
      logic [1:0]  ph;
   } smp_t;

   int   tests = 0;
   int   fails = 0;
   st_t  st_q[$];
   smp_t sm_q[$];

   // Reference model: blocks and samples as plain counts, delays as value histories.
   int m_level, m_nblk, m_ntot, m_rphase;
   bit m_ul, m_tap, m_latch, m_first;
   bit wr_h[$];
   bit lat_h[$];
   bit sf_h[$];
   bit p_acc, p_fin, p_wr;
   st_t p_st;

   function automatic bit past(input bit h[$], input int n);
      return (h.size() >= n) ? h[h.size()-n] : 1'b0;
   endfunction

   function automatic void predict();
      bit mode, first;
      mode  = (m_level > 0);
      first = m_first & m_latch;
      p_wr  = m_latch & ~first;
      p_st.rdy    = (m_level != DEPTH) && !past(wr_h, WRD) && !past(lat_h, LATD);
      p_acc       = error_in_vld && p_st.rdy;
      p_fin       = p_acc && (m_nblk == int'(tap_len));
      p_st.level  = 2'(m_level);
      p_st.mode   = mode;
      p_st.latch  = m_latch;
      p_st.first  = first;
      p_st.tapo   = m_tap & ~input_stage;
      p_st.fintap = state_finish & m_latch & m_tap;
      p_st.smode  = past(lat_h, STGD);
      p_st.sfirst = past(sf_h, STGD);
      p_st.rph    = 2'(m_rphase);
      p_st.cnt    = 4'(m_nblk);
      p_st.sub    = 3'(m_ntot % SUBW);
      p_st.ph     = 2'((m_ntot / SUBW) % NPH);
   endfunction

   function automatic void model_step();
      bit mode, cons, n_first;
      if (reset) begin
         m_level = 0; m_nblk = 0; m_ntot = 0; m_rphase = 0;
         m_ul = 0; m_tap = 0; m_latch = 0; m_first = 0;
         wr_h.delete(); lat_h.delete(); sf_h.delete();
         return;
      end
      mode = (m_level > 0);
      cons = m_ul && m_tap;
      wr_h.push_back(p_wr);
      lat_h.push_back(m_latch);
      sf_h.push_back(m_first & m_latch);
      if (p_acc) begin
         m_ntot++;
         m_nblk = p_fin ? 0 : (m_nblk + 1) % 16;
      end
      if (flush)                m_level = 0;
      else if (p_fin && cons)   m_level = m_level;
      else if (p_fin)           m_level = (m_level < DEPTH) ? m_level + 1 : DEPTH;
      else if (cons)            m_level = (m_level > 0) ? m_level - 1 : 0;
      n_first = state_finish ? (mode && read_finish) : (m_latch && read_finish);
      if (m_first && (!m_tap || input_stage)) m_rphase = (m_rphase + 1) % NPH;
      if (state_finish) m_latch = mode;
      m_tap   = input_stage ? 1'b1 : (m_ul ? !m_tap : m_tap);
      m_ul    = mode && state_finish;
      m_first = n_first;
   endfunction

   task automatic drive(input logic r, input logic v, input logic [31:0] d, input logic sf,
                        input logic rf, input logic is, input logic fl);
      reset = r; error_in_vld = v; error_in = d; state_finish = sf;
      read_finish = rf; input_stage = is; flush = fl;
      predict();
      st_q.push_back(p_st);
      if (p_acc) sm_q.push_back('{data: d, cnt: p_st.cnt, sub: p_st.sub, ph: p_st.ph});
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 32'h0, 0, 0, 0, 0);
   endtask

   task automatic samples(input int n);
      for (int i = 0; i < n; i++) drive(0, 1, $urandom, 0, 0, 0, 0);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   st_t  a_st, e_st;
   smp_t a_sm, e_sm;
   always @(negedge clk) begin
      if (st_q.size() > 0) begin
         e_st = st_q.pop_front();
         a_st = '{rdy: error_in_rdy, level: fifo_level, mode: error_update_mode,
                  latch: error_update_latch, first: error_update_first,
                  tapo: error_tap_update_out, fintap: error_finish_tap,
                  smode: stage_error_mode, sfirst: stage_error_first,
                  rph: error_phase_read, cnt: error_count, sub: error_sub_address,
                  ph: error_phase};
         tests++;
         if (a_st !== e_st) begin
            fails++;
            $display("FAIL status at %0t: got %h, expected %h", $time, a_st, e_st);
         end
      end
      if (error_valid === 1'b1) begin
         a_sm = '{data: error_value, cnt: error_count, sub: error_sub_address, ph: error_phase};
         tests++;
         if (sm_q.size() == 0) begin
            fails++;
            $display("FAIL sample at %0t: got %h, expected no accepted sample", $time, a_sm);
         end else begin
            e_sm = sm_q.pop_front();
            if (a_sm !== e_sm) begin
               fails++;
               $display("FAIL sample at %0t: got %h, expected %h", $time, a_sm, e_sm);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      @(posedge clk);
      model_step();
      #1;
      drive(1, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 0);
      chk("reset_level", int'(fifo_level), 0);
      chk("reset_rdy", int'(error_in_rdy), 1);
      idle(2);

      // one block of four samples
      samples(4);
      chk("one_block_level", int'(fifo_level), 1);
      chk("one_block_mode", int'(error_update_mode), 1);
      // second block fills the FIFO; further samples are held off
      samples(4);
      chk("full_level", int'(fifo_level), 2);
      chk("full_rdy", int'(error_in_rdy), 0);
      samples(3);
      chk("held_count", int'(error_count), 0);
      drive(0, 0, 0, 0, 0, 0, 1);
      chk("flush_level", int'(fifo_level), 0);
      chk("flush_rdy", int'(error_in_rdy), 1);

      // update pass consumes a block
      drive(0, 0, 0, 0, 0, 1, 0);
      samples(4);
      drive(0, 0, 0, 1, 1, 0, 0);
      chk("latch_set", int'(error_update_latch), 1);
      idle(1);
      chk("consume_level", int'(fifo_level), 0);
      idle(4);
      drive(0, 0, 0, 1, 0, 0, 0);
      idle(8);

      // finish coincident with consume
      drive(0, 0, 0, 0, 0, 1, 0);
      samples(4);
      samples(3);
      drive(0, 0, 0, 1, 0, 0, 0);
      drive(0, 1, $urandom, 0, 0, 0, 0);
      chk("fin_consume_level", int'(fifo_level), 1);
      drive(0, 0, 0, 0, 0, 0, 1);
      drive(0, 0, 0, 1, 0, 0, 0);
      idle(8);

      // sub-address and phase wrap
      drive(1, 0, 0, 0, 0, 0, 0);
      tap_len = 4'd15;
      samples(13);
      chk("sub_after_13", int'(error_sub_address), 1);
      chk("phase_after_13", int'(error_phase), 2);
      samples(11);
      chk("sub_after_24", int'(error_sub_address), 0);
      chk("phase_after_24", int'(error_phase), 0);

      // random traffic
      drive(1, 0, 0, 0, 0, 0, 0);
      tap_len = 4'd2;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 49) == 0) tap_len = 4'($urandom_range(0, 5));
         drive(($urandom_range(0, 399) == 0), ($urandom_range(0, 3) != 0), $urandom,
               ($urandom_range(0, 9) == 0), $urandom_range(0, 1),
               ($urandom_range(0, 15) == 0), ($urandom_range(0, 59) == 0));
      end
      idle(2);
      chk("sample_queue_empty", sm_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
